voice_allocator: RTL
====================

// Module: voice_allocator
// PURPOSE
//  Polyphonic voice scheduler that sits in front of NUM_VOICES NCO instances.
//  Accepts note-on/note-off events over a valid/ready handshake and assigns each note to a voice.
//  Drives each NCO's loadF strobe, shared F_in tuning bus and key_on gate (key_on feeds the ADSR).
//  On note-on: re-uses the voice already holding that note, else takes a released voice, else steals the oldest held voice.
// PARAMETERS
//  NUM_VOICES  8   number of NCO voices managed (2..16)
//  NOTE_W      7   note-number width
//  FREQ_W      24  tuning-word width, matches the NCO F_in port
//  AGE_W       8   per-voice age counter width (saturating)
// PORTS
//  Clk           in   1                  system clock
//  Reset         in   1                  asynchronous, active-low reset
//  evt_valid     in   1                  event present
//  evt_ready     out  1                  allocator can accept; high only in IDLE with panic low
//  evt_on        in   1                  1 = note-on, 0 = note-off
//  evt_note      in   NOTE_W             note number
//  evt_freq      in   FREQ_W             tuning word; ignored for note-off
//  panic         in   1                  all-notes-off request
//  voice_F       out  FREQ_W             shared tuning-word bus to every NCO F_in
//  voice_loadF   out  NUM_VOICES         one-hot, one-cycle load strobe per NCO
//  voice_key_on  out  NUM_VOICES         gate level per NCO/ADSR
//  busy          out  1                  state != IDLE
// BEHAVIOUR
//  Reset (async, Reset==0): state=IDLE. voice_F, voice_loadF and voice_key_on are 0. Every note_tag and age is 0.
//    evt_ready follows the IDLE rule and reads 1 once panic is low.
//  FSM states: IDLE -> SCAN -> COMMIT -> (RETRIG) -> IDLE.
//  IDLE: on evt_valid&&evt_ready (cycle T), capture evt_on, evt_note and evt_freq, then go to SCAN.
//  SCAN (T+1): register the selected index sel and the flag need_retrig = voice_key_on[sel].
//    Note-on selection priority:
//      (1) a key_on voice whose note_tag==note, lowest index;
//      (2) a key_off voice with the largest age, ties to lowest index;
//      (3) a key_on voice with the largest age, ties to lowest index (steal).
//    Note-off: match = a key_on voice with note_tag==note, lowest index.
//      No match: flag nop; COMMIT then does nothing.
//  COMMIT (T+2):
//    Note-on:
//      - voice_F<=freq, voice_loadF[sel]<=1 for 1 cycle, note_tag[sel]<=note.
//      - age[sel]<=0; every other age +1, saturating at 2^AGE_W-1.
//      - need_retrig=0: key_on[sel]<=1, then IDLE.
//      - need_retrig=1: key_on[sel]<=0, then RETRIG.
//    Note-off match: key_on[sel]<=0; note_tag and ages unchanged.
//  RETRIG (T+3): key_on[sel]<=1, so the ADSR sees a fresh rising edge. Then IDLE.
//  Latency: free-voice note-on gates at T+2, ready at T+3. Steal or same-note gates at T+3, ready at T+4.
//    Note-off gate drops at T+2.
//  voice_F holds its last value between loads. voice_loadF is zero outside COMMIT.
//  panic: when sampled high in any state, next cycle key_on=0 for all voices, loadF=0, state=IDLE.
//    Any in-flight event is discarded; ages and note tags are kept.
//    panic beats a same-cycle handshake: evt_ready is low while panic is high.
//  Duplicate note-on for a held note re-uses that voice: loads the new freq and retriggers.
//    Never more than one key_on voice per note.
//  Reset mid-operation aborts immediately; no strobe is emitted after Reset falls.
// STRUCTURE
//  synth_pkg: alloc_state_t enum {IDLE,SCAN,COMMIT,RETRIG}; localparam VIDX_W=$clog2(NUM_VOICES).
//  Sub-module voice_select: combinational priority/max-age finder.
//    Inputs: key_on, note_tags, ages, note, evt_on. Outputs: sel, need_retrig, nop.
//  Top: FSM, capture regs, per-voice note_tag/age arrays, output regs.
// TESTING
//  After reset: 8 note-ons A..H with distinct freq -> voices 0..7 loaded in order;
//    each loadF one cycle at T+2 with voice_F==evt_freq.
//  Note-off for the note on voice 3, then new note-on -> voice 3 re-used (only released voice);
//    key_on[3] 1->0->1 across events.
//  All voices held, 9th note-on -> the voice with the largest age (voice 0) is stolen.
//    key_on[0]=0 at T+2 and 1 at T+3; loadF[0] pulse at T+2; ready at T+4.
//  Note-on for a note already held on voice 5 with new freq -> voice 5 reloaded and retriggered;
//    no other voice changes.
//  Note-off for an unheld note -> no output change; ready back at T+3.
//  panic asserted during SCAN with all voices on -> all key_on=0 next cycle, no loadF, IDLE;
//    panic held with evt_valid=1 -> event not accepted.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared state encoding and sizing helpers for the polyphonic voice allocator.
package synth_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      COMMIT = 2'd2,
      RETRIG = 2'd3
   } alloc_state_t;

   localparam int NUM_VOICES_DFLT = 8;
   localparam int VIDX_W          = $clog2(NUM_VOICES_DFLT);

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/voice_select.sv
// Combinational voice chooser: same-note match first, then the oldest released
// voice, then the oldest held voice (steal).
module voice_select
   import synth_pkg::*;
#(
   parameter int NUM_VOICES = 8,
   parameter int NOTE_W     = 7,
   parameter int AGE_W      = 8,
   localparam int VW        = idx_width(NUM_VOICES)
) (
   input  logic [NUM_VOICES-1:0] key_on_i,
   input  logic [NOTE_W-1:0]     note_tags_i [NUM_VOICES],
   input  logic [AGE_W-1:0]      ages_i [NUM_VOICES],
   input  logic [NOTE_W-1:0]     note_i,
   input  logic                  evt_on_i,
   output logic [VW-1:0]         sel_o,
   output logic                  need_retrig_o,
   output logic                  nop_o
);

   logic              match_found_s, free_found_s;
   logic [VW-1:0]     match_idx_s, free_idx_s, held_idx_s;
   logic [AGE_W-1:0]  free_age_s, held_age_s;

   // Scan all voices; strict '>' keeps ties on the lowest index.
   always_comb begin
      match_found_s = 1'b0;
      free_found_s  = 1'b0;
      match_idx_s   = '0;
      free_idx_s    = '0;
      held_idx_s    = '0;
      free_age_s    = '0;
      held_age_s    = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (key_on_i[i]) begin
            if (!match_found_s && (note_tags_i[i] == note_i)) begin
               match_found_s = 1'b1;
               match_idx_s   = VW'(i);
            end else begin
               match_found_s = match_found_s;
            end
            if (ages_i[i] > held_age_s) begin
               held_age_s = ages_i[i];
               held_idx_s = VW'(i);
            end else begin
               held_age_s = held_age_s;
            end
         end else begin
            if (!free_found_s || (ages_i[i] > free_age_s)) begin
               free_found_s = 1'b1;
               free_age_s   = ages_i[i];
               free_idx_s   = VW'(i);
            end else begin
               free_found_s = free_found_s;
            end
         end
      end
   end

   // Resolve the priority order for note-on versus note-off.
   always_comb begin
      if (!evt_on_i || match_found_s) begin
         sel_o = match_idx_s;
      end else if (free_found_s) begin
         sel_o = free_idx_s;
      end else begin
         sel_o = held_idx_s;
      end
      nop_o         = !evt_on_i && !match_found_s;
      need_retrig_o = key_on_i[sel_o];
   end

endmodule

// File: rtl/voice_allocator.sv
// Voice allocator top: event handshake, IDLE/SCAN/COMMIT/RETRIG sequencing,
// per-voice note tags and ages, and registered NCO/ADSR control outputs.
module voice_allocator
   import synth_pkg::*;
#(
   parameter int NUM_VOICES = 8,
   parameter int NOTE_W     = 7,
   parameter int FREQ_W     = 24,
   parameter int AGE_W      = 8
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  evt_valid,
   output logic                  evt_ready,
   input  logic                  evt_on,
   input  logic [NOTE_W-1:0]     evt_note,
   input  logic [FREQ_W-1:0]     evt_freq,
   input  logic                  panic,
   output logic [FREQ_W-1:0]     voice_F,
   output logic [NUM_VOICES-1:0] voice_loadF,
   output logic [NUM_VOICES-1:0] voice_key_on,
   output logic                  busy
);

   localparam int VW = idx_width(NUM_VOICES);
   localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

   alloc_state_t              state_q, state_d;
   logic                      on_q, on_d;
   logic [NOTE_W-1:0]         note_q, note_d;
   logic [FREQ_W-1:0]         freq_q, freq_d;
   logic [VW-1:0]             sel_q, sel_d;
   logic                      retrig_q, retrig_d;
   logic [FREQ_W-1:0]         f_q, f_d;
   logic [NUM_VOICES-1:0]     loadf_q, loadf_d;
   logic [NUM_VOICES-1:0]     key_on_q, key_on_d;
   logic [NOTE_W-1:0]         tag_q [NUM_VOICES];
   logic [NOTE_W-1:0]         tag_d [NUM_VOICES];
   logic [AGE_W-1:0]          age_q [NUM_VOICES];
   logic [AGE_W-1:0]          age_d [NUM_VOICES];

   logic [VW-1:0]             sel_s;
   logic                      retrig_s;
   logic                      nop_s;

   function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
      return (a == AGE_MAX) ? a : a + {{(AGE_W-1){1'b0}}, 1'b1};
   endfunction

   voice_select #(
      .NUM_VOICES (NUM_VOICES),
      .NOTE_W     (NOTE_W),
      .AGE_W      (AGE_W)
   ) u_select (
      .key_on_i      (key_on_q),
      .note_tags_i   (tag_q),
      .ages_i        (age_q),
      .note_i        (note_q),
      .evt_on_i      (on_q),
      .sel_o         (sel_s),
      .need_retrig_o (retrig_s),
      .nop_o         (nop_s)
   );

   assign evt_ready    = (state_q == IDLE) && !panic;
   assign busy         = (state_q != IDLE);
   assign voice_F      = f_q;
   assign voice_loadF  = loadf_q;
   assign voice_key_on = key_on_q;

   // Next-state logic; commit effects are registered on the SCAN exit edge so
   // they are visible on the outputs for exactly the COMMIT cycle.
   always_comb begin
      state_d  = state_q;
      on_d     = on_q;
      note_d   = note_q;
      freq_d   = freq_q;
      sel_d    = sel_q;
      retrig_d = retrig_q;
      f_d      = f_q;
      loadf_d  = '0;
      key_on_d = key_on_q;
      tag_d    = tag_q;
      age_d    = age_q;
      if (panic) begin
         state_d  = IDLE;
         key_on_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (evt_valid) begin
                  on_d    = evt_on;
                  note_d  = evt_note;
                  freq_d  = evt_freq;
                  state_d = SCAN;
               end else begin
                  state_d = IDLE;
               end
            end
            SCAN: begin
               sel_d    = sel_s;
               retrig_d = retrig_s;
               state_d  = COMMIT;
               if (on_q) begin
                  f_d             = freq_q;
                  loadf_d[sel_s]  = 1'b1;
                  tag_d[sel_s]    = note_q;
                  key_on_d[sel_s] = !retrig_s;
                  for (int i = 0; i < NUM_VOICES; i++) begin
                     age_d[i] = (VW'(i) == sel_s) ? '0 : sat_inc(age_q[i]);
                  end
               end else if (!nop_s) begin
                  key_on_d[sel_s] = 1'b0;
               end else begin
                  key_on_d = key_on_q;
               end
            end
            COMMIT: begin
               if (on_q && retrig_q) begin
                  key_on_d[sel_q] = 1'b1;
                  state_d         = RETRIG;
               end else begin
                  state_d = IDLE;
               end
            end
            RETRIG: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State, capture and output registers.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q  <= IDLE;
         on_q     <= 1'b0;
         note_q   <= '0;
         freq_q   <= '0;
         sel_q    <= '0;
         retrig_q <= 1'b0;
         f_q      <= '0;
         loadf_q  <= '0;
         key_on_q <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            tag_q[i] <= '0;
            age_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         on_q     <= on_d;
         note_q   <= note_d;
         freq_q   <= freq_d;
         sel_q    <= sel_d;
         retrig_q <= retrig_d;
         f_q      <= f_d;
         loadf_q  <= loadf_d;
         key_on_q <= key_on_d;
         tag_q    <= tag_d;
         age_q    <= age_d;
      end
   end

endmodule
